// File: rtl/pipelined_antilog_converter_if.sv
// pipelined_antilog_converter_if: log-domain input beat and linear result beat with valid/ready
interface pipelined_antilog_converter_if #(
    parameter int K_W   = 4,
    parameter int F_W   = 7,
    parameter int OUT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [K_W+F_W-1:0]   log_result;
    logic                 fraction_sum_carry;
    logic                 in_zero;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     result;
    logic                 overflow;
    modport master (
        output in_valid, log_result, fraction_sum_carry, in_zero, out_ready,
        input  in_ready, out_valid, result, overflow
    );
    modport slave (
        input  in_valid, log_result, fraction_sum_carry, in_zero, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/pipelined_antilog_converter.sv
// pipelined_antilog_converter: 2-stage log-to-linear antilog with carry, zero bypass, saturation and backpressure
// Define ANTILOG_ROUND_EN for round-half-up instead of truncation.
module pipelined_antilog_converter #(
    parameter int K_W   = 4,
    parameter int F_W   = 7,
    parameter int OUT_W = 16
) (
    input logic clk,
    input logic reset,
    pipelined_antilog_converter_if.slave bus
);
    localparam int E_W  = K_W + 1;
    localparam int SH_W = F_W + (2 ** E_W);
    logic             s1_valid;
    logic             s1_zero;
    logic [E_W-1:0]   s1_k;
    logic [F_W:0]     s1_m;
    logic             s1_load;
    logic             s2_load;
    logic             ovf;
    logic [SH_W-1:0]  raw;
    logic [OUT_W-1:0] res;
    assign s2_load     = !bus.out_valid || bus.out_ready;
    assign s1_load     = !s1_valid || s2_load;
    assign bus.in_ready = s1_load;
`ifdef ANTILOG_ROUND_EN
    logic [SH_W-1:0] half;
    // keep one extra fractional bit so its value can round the result up
    assign half = (SH_W'(s1_m) << s1_k) >> (F_W - 1);
    assign raw  = (half >> 1) + SH_W'(half[0]);
`else
    assign raw = (SH_W'(s1_m) << s1_k) >> F_W;
`endif
    assign ovf = !s1_zero && |raw[SH_W-1:OUT_W];
    assign res = s1_zero ? '0 : ovf ? '1 : raw[OUT_W-1:0];
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_zero       <= 1'b0;
            s1_k          <= '0;
            s1_m          <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.overflow  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_k    <= E_W'(bus.log_result[K_W+F_W-1:F_W]) + E_W'(bus.fraction_sum_carry);
                    s1_m    <= {1'b1, bus.log_result[F_W-1:0]};
                    s1_zero <= bus.in_zero;
                end
            end
            if (s2_load) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.result   <= res;
                    bus.overflow <= ovf;
                end
            end
        end
    end
endmodule
